// File: rtl/countdown_timer_if.sv
// Countdown timer board I/O bundle.
// Raw active-low keys in, BCD digits and LEDs out.
interface countdown_timer_if;
  logic       key_min;
  logic       key_sec;
  logic       key_start_pause;
  logic [3:0] minute_high;
  logic [3:0] minute_low;
  logic [3:0] second_high;
  logic [3:0] second_low;
  logic [3:0] msecond_high;
  logic [3:0] msecond_low;
  logic       running;
  logic       alarm;

  modport master (
    output key_min, key_sec, key_start_pause,
    input  minute_high, minute_low,
    input  second_high, second_low,
    input  msecond_high, msecond_low,
    input  running, alarm
  );

  modport slave (
    input  key_min, key_sec, key_start_pause,
    output minute_high, minute_low,
    output second_high, second_low,
    output msecond_high, msecond_low,
    output running, alarm
  );
endinterface

// File: rtl/countdown_timer.sv
// mm:ss.cc countdown timer with key debounce,
// pause/resume and a blinking expiry alarm.
module countdown_timer #(
  parameter int TICK_DIV        = 500000,
  parameter int DEBOUNCE_CYCLES = 255,
  parameter int BLINK_TICKS     = 50
) (
  input  logic CLOCK_50,
  input  logic reset,
  countdown_timer_if.slave io
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE, RUN, PAUSE, EXPIRED
  } state_t;

  state_t state, state_nxt;

  logic [2:0]    raw, sync1, sync2;
  logic [2:0]    pressed, pulse;
  logic [DW-1:0] db_cnt [3];

  logic [7:0]    pre_m, pre_s;
  logic [7:0]    pre_m_nxt, pre_s_nxt;
  logic [23:0]   cnt, cnt_dec;
  logic [PW-1:0] presc, presc_inc;
  logic [BW-1:0] blink;
  logic          alarm_q;

  logic tick, act_sp, act_min, act_sec;
  logic any_pulse, dec_zero, preset_nz;

  function automatic logic [7:0] inc59(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  d, lim;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d   = v[i*4 +: 4];
      lim = (i == 3) ? 4'd5 : 4'd9;
      if (b) begin
        if (d == 4'd0) begin
          r[i*4 +: 4] = lim;
        end else begin
          r[i*4 +: 4] = d - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign raw = {io.key_start_pause, io.key_sec, io.key_min};

  // two-flop synchronizer, idles released (high)
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // debounce: flip accepted level after a full run of disagreeing samples
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pressed <= '0;
      pulse   <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        pulse[i] <= 1'b0;
        if (sync2[i] == pressed[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            pressed[i] <= ~pressed[i];
            pulse[i]   <= ~pressed[i];
            db_cnt[i]  <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign act_sp    = pulse[2];
  assign act_min   = pulse[0] & ~pulse[2];
  assign act_sec   = pulse[1] & ~pulse[2] & ~pulse[0];
  assign any_pulse = |pulse;

  assign tick      = (presc == PW'(TICK_DIV - 1));
  assign presc_inc = tick ? '0 : presc + 1'b1;
  assign cnt_dec   = bcd_dec(cnt);
  assign dec_zero  = (cnt_dec == 24'h0);
  assign preset_nz = |{pre_m, pre_s};

  // preset edits only while idle
  always_comb begin
    pre_m_nxt = pre_m;
    pre_s_nxt = pre_s;
    if (state == IDLE && act_min) pre_m_nxt = inc59(pre_m);
    if (state == IDLE && act_sec) pre_s_nxt = inc59(pre_s);
  end

  // state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state; expiry wins over a same-cycle pause
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (act_sp && preset_nz) state_nxt = RUN;
      RUN: begin
        if (tick && dec_zero) state_nxt = EXPIRED;
        else if (act_sp)      state_nxt = PAUSE;
      end
      PAUSE: begin
        if (act_sp)       state_nxt = RUN;
        else if (act_min) state_nxt = IDLE;
      end
      EXPIRED: if (any_pulse) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // preset, count, prescaler and alarm blink
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pre_m   <= '0;
      pre_s   <= '0;
      cnt     <= '0;
      presc   <= '0;
      blink   <= '0;
      alarm_q <= 1'b0;
    end else begin
      pre_m <= pre_m_nxt;
      pre_s <= pre_s_nxt;
      unique case (state)
        IDLE: begin
          cnt   <= {pre_m_nxt, pre_s_nxt, 8'h00};
          presc <= '0;
        end
        RUN: begin
          presc <= presc_inc;
          if (tick) cnt <= cnt_dec;
          if (state_nxt == EXPIRED) begin
            alarm_q <= 1'b1;
            blink   <= '0;
          end
        end
        PAUSE: begin
          if (state_nxt == IDLE) begin
            cnt   <= {pre_m, pre_s, 8'h00};
            presc <= '0;
          end
        end
        EXPIRED: begin
          if (state_nxt == IDLE) begin
            cnt     <= {pre_m, pre_s, 8'h00};
            presc   <= '0;
            blink   <= '0;
            alarm_q <= 1'b0;
          end else begin
            presc <= presc_inc;
            if (tick) begin
              if (blink == BW'(BLINK_TICKS - 1)) begin
                blink   <= '0;
                alarm_q <= ~alarm_q;
              end else begin
                blink <= blink + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io.minute_high  = cnt[23:20];
  assign io.minute_low   = cnt[19:16];
  assign io.second_high  = cnt[15:12];
  assign io.second_low   = cnt[11:8];
  assign io.msecond_high = cnt[7:4];
  assign io.msecond_low  = cnt[3:0];
  assign io.running      = (state == RUN);
  assign io.alarm        = alarm_q;
endmodule
